apb_requester: RTL and testbench

Parametrised APB4 requester (bridge-side master) that converts a simple valid/ready request port into compliant IDLE/SETUP/ACCESS bus transfers. It generalises the team's fixed 10-bit address / 32-bit data APB types to any width, and adds write strobes, wait-state handling, a registered response channel and an optional transfer timeout. It sits between an internal command source (CPU port, DMA, test sequencer) and an APB completer such as the dual-port memory.

---
 rtl/apb_requester.sv | 196 +++++++++++++++++++
 tb/tb_apb_requester.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_requester.sv
// APB4 requester: turns a valid/ready request into IDLE/SETUP/ACCESS transfers with a registered response.
// Optional transfer timeout is compiled in with `define APB_REQ_TIMEOUT_EN.
module apb_requester #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_write,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_strb,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_slverr,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic [STRB_WIDTH-1:0] pstrb,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    accept_s;
    logic                    complete_s;
    logic                    abort_s;
    logic                    timeout_hit_s;

    logic                    req_ready_r;
    logic                    psel_r;
    logic                    penable_r;
    logic                    pwrite_r;
    logic [ADDR_WIDTH-1:0]   paddr_r;
    logic [DATA_WIDTH-1:0]   pwdata_r;
    logic [STRB_WIDTH-1:0]   pstrb_r;
    logic                    rsp_valid_r;
    logic [DATA_WIDTH-1:0]   rsp_rdata_r;
    logic                    rsp_slverr_r;
    logic                    rsp_timeout_r;

`ifdef APB_REQ_TIMEOUT_EN
    localparam int                   CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [CNT_WIDTH-1:0] wait_cnt_r;

    // Wait-state counter: cleared in SETUP so it starts at zero on entry to ACCESS.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wait_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (state_r == ST_SETUP) begin
            wait_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if ((state_r == ST_ACCESS) && !pready) begin
            wait_cnt_r <= wait_cnt_r + CNT_WIDTH'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // The limit is hit on the last allowed low-pready ACCESS cycle; pready high there still wins.
    assign timeout_hit_s = (state_r == ST_ACCESS) && !pready && (wait_cnt_r == CNT_LAST);
`else
    assign timeout_hit_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode plus the accept/complete/abort events.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        complete_s  = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_SETUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_nxt_s = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    complete_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (timeout_hit_s) begin
                    abort_s     = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Bus control and req_ready registered from the next state so they track the FSM exactly.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            req_ready_r <= 1'b1;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
        end else begin
            req_ready_r <= (state_nxt_s == ST_IDLE);
            psel_r      <= (state_nxt_s != ST_IDLE);
            penable_r   <= (state_nxt_s == ST_ACCESS);
        end
    end

    // Request latch; reads carry zero data and strobes, and values hold between transfers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pwrite_r <= 1'b0;
            paddr_r  <= {ADDR_WIDTH{1'b0}};
            pwdata_r <= {DATA_WIDTH{1'b0}};
            pstrb_r  <= {STRB_WIDTH{1'b0}};
        end else if (accept_s) begin
            pwrite_r <= req_write;
            paddr_r  <= req_addr;
            pwdata_r <= req_write ? req_wdata : {DATA_WIDTH{1'b0}};
            pstrb_r  <= req_write ? req_strb  : {STRB_WIDTH{1'b0}};
        end else begin
            pwrite_r <= pwrite_r;
            paddr_r  <= paddr_r;
            pwdata_r <= pwdata_r;
            pstrb_r  <= pstrb_r;
        end
    end

    // Response channel: one-cycle valid pulse, payload held until the next response.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
            rsp_slverr_r  <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else if (complete_s) begin
            rsp_valid_r   <= 1'b1;
            rsp_rdata_r   <= pwrite_r ? {DATA_WIDTH{1'b0}} : prdata;
            rsp_slverr_r  <= pslverr;
            rsp_timeout_r <= 1'b0;
        end else if (abort_s) begin
            rsp_valid_r   <= 1'b1;
            rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
            rsp_slverr_r  <= 1'b1;
            rsp_timeout_r <= 1'b1;
        end else begin
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= rsp_rdata_r;
            rsp_slverr_r  <= rsp_slverr_r;
            rsp_timeout_r <= rsp_timeout_r;
        end
    end

    assign req_ready   = req_ready_r;
    assign psel        = psel_r;
    assign penable     = penable_r;
    assign pwrite      = pwrite_r;
    assign paddr       = paddr_r;
    assign pwdata      = pwdata_r;
    assign pstrb       = pstrb_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_slverr  = rsp_slverr_r;
    assign rsp_timeout = rsp_timeout_r;

endmodule

// File: tb/tb_apb_requester.sv
// Scoreboard bench for apb_requester: a completer model follows a per-transfer wait/data plan,
// and a response monitor compares each response with the outcome predicted from the request.
module tb_apb_requester;

    localparam int TO = 4;
`ifdef APB_REQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        logic [9:0]  addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic [31:0] rdata;
        logic        slverr;
        int          acc;
    } xfer_t;

    logic        pclk;
    logic        presetn;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [9:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    xfer_t plan_q[$];
    xfer_t exp_q[$];

    apb_requester #(
        .ADDR_WIDTH(10), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
        .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        forever begin
            @(posedge pclk);
            cyc = cyc + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [46:0] bus_exp(input xfer_t x);
        return {x.addr, x.write, (x.write ? x.wdata : 32'h0), (x.write ? x.strb : 4'h0)};
    endfunction

    function automatic xfer_t mk(input logic [9:0] a, input logic w, input logic [31:0] d,
                                 input logic [3:0] s, input int wt, input logic [31:0] rd,
                                 input logic se);
        xfer_t x;
        x.addr = a; x.write = w; x.wdata = d; x.strb = s;
        x.waits = wt; x.rdata = rd; x.slverr = se; x.acc = 0;
        return x;
    endfunction

    function automatic xfer_t rnd();
        return mk(10'($urandom), 1'($urandom), $urandom, 4'($urandom),
                  int'($urandom_range(0, TO_EN ? 6 : 3)), $urandom, 1'($urandom_range(0, 1)));
    endfunction

    // Completer model: honours the planned wait count, randomises everything it is allowed to.
    initial begin
        xfer_t cur;
        int    wc;
        bit    have;
        pready = 1'b0; pslverr = 1'b0; prdata = 32'h0; have = 1'b0; wc = 0;
        forever begin
            @(negedge pclk);
            if (presetn && psel && !penable) begin
                chk("setup_has_req", 64'(plan_q.size() != 0), 64'd1);
                if (plan_q.size() != 0) begin
                    cur  = plan_q.pop_front();
                    have = 1'b1;
                    wc   = 0;
                    chk("setup_bus", 64'({paddr, pwrite, pwdata, pstrb}), 64'(bus_exp(cur)));
                end
                pready = 1'($urandom_range(0, 1)); pslverr = 1'($urandom_range(0, 1)); prdata = $urandom;
            end else if (presetn && psel && penable && have) begin
                chk("access_bus", 64'({paddr, pwrite, pwdata, pstrb}), 64'(bus_exp(cur)));
                if (wc < cur.waits) begin
                    pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
                    wc++;
                end else begin
                    pready = 1'b1; prdata = cur.rdata; pslverr = cur.slverr;
                end
            end else begin
                pready = 1'($urandom_range(0, 1)); pslverr = 1'($urandom_range(0, 1)); prdata = $urandom;
            end
        end
    end

    // Response monitor: pops the oldest outstanding request and checks payload and latency.
    initial begin
        xfer_t e;
        bit    to;
        forever begin
            @(negedge pclk);
            if (presetn && rsp_valid) begin
                chk("rsp_has_req", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e  = exp_q.pop_front();
                    to = TO_EN && (e.waits >= TO);
                    chk("rsp_fields", 64'({rsp_rdata, rsp_slverr, rsp_timeout}),
                        64'({((e.write || to) ? 32'h0 : e.rdata), (e.slverr || to), to}));
                    chk("rsp_latency", 64'(cyc - e.acc), 64'(to ? (1 + TO) : (2 + e.waits)));
                    chk("rsp_bus_idle", 64'({psel, penable, req_ready}), 64'd1);
                end
            end
        end
    end

    task automatic send(input xfer_t x, output int acc);
        xfer_t y;
        int    n;
        @(negedge pclk);
        req_addr = x.addr; req_write = x.write; req_wdata = x.wdata; req_strb = x.strb;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge pclk);
            n++;
        end
        chk("accept_in_time", 64'(req_ready), 64'd1);
        if (req_ready) begin
            y = x;
            y.acc = cyc + 1;
            acc = y.acc;
            plan_q.push_back(y);
            exp_q.push_back(y);
            @(posedge pclk);
        end else begin
            acc = -1;
        end
        #1 req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge pclk);
    endtask

    initial begin
        int a0;
        int a1;
        int n;
        presetn = 1'b0; req_valid = 1'b0;
        req_addr = 10'h0; req_write = 1'b0; req_wdata = 32'h0; req_strb = 4'h0;
        idle(2);
        chk("reset_bus", 64'({psel, penable, pwrite, paddr, pwdata, pstrb}), 64'd0);
        chk("reset_rsp", 64'({rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, req_ready}), 64'd1);
        @(negedge pclk);
        presetn = 1'b1;

        send(mk(10'h3FC, 1'b1, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0), a0);
        idle(5);
        send(mk(10'h010, 1'b0, 32'hCAFEF00D, 4'hF, 2, 32'h12345678, 1'b0), a0);
        idle(6);
        send(mk(10'h155, 1'b1, 32'hA5A5A5A5, 4'h5, 1, 32'h0, 1'b1), a0);
        send(mk(10'h2AA, 1'b1, 32'h0BADCAFE, 4'h0, 0, 32'h0, 1'b0), a0);
        idle(5);
        send(mk(10'h07F, 1'b0, 32'h0, 4'h3, 10, 32'h87654321, 1'b0), a0);
        idle(16);

        // Reset while the bus is in ACCESS: nothing may come back for the dropped request.
        send(mk(10'h0C3, 1'b0, 32'h0, 4'h0, 5, 32'h11112222, 1'b0), a0);
        n = 0;
        while (!(psel && penable) && n < 20) begin
            @(negedge pclk);
            n++;
        end
        chk("reached_access", 64'({psel, penable}), 64'd3);
        presetn = 1'b0;
        #1;
        chk("reset_mid_xfer", 64'({psel, penable, rsp_valid, req_ready}), 64'd1);
        plan_q.delete();
        exp_q.delete();
        @(negedge pclk);
        presetn = 1'b1;
        idle(10);

        send(mk(10'h100, 1'b1, 32'h01020304, 4'hC, 0, 32'h0, 1'b0), a0);
        send(mk(10'h104, 1'b0, 32'h0, 4'h0, 0, 32'h55AA55AA, 1'b0), a1);
        chk("b2b_spacing", 64'(a1 - a0), 64'd3);
        idle(5);

        for (int i = 0; i < 40; i++) begin
            send(rnd(), a0);
            idle(int'($urandom_range(0, 2)));
        end

        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge pclk);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
